// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// Bundles the two master request channels, the forwarded decoder bus and the
// unmapped-access status flags of the system-bus arbiter.
//   slave  modport : arbiter side (takes requests, drives grants/acks/bus/err)
//   master modport : requester/decoder side (the mirror image)
// Signals:
//   req0/req1, we0/we1, a0/a1, wd0/wd1 : master requests, write enables, address, write data
//   gnt0/gnt1, ack0/ack1, rd           : grants, beat accepts, shared read data
//   bus_a, bus_we, bus_wd, bus_rd      : decoder-facing bus
//   err, err_addr, err_cnt             : unmapped-access pulse, last bad address, count
interface bus_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        gnt0;
    logic        gnt1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rd;
    logic [31:0] bus_a;
    logic        bus_we;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        err;
    logic [31:0] err_addr;
    logic [7:0]  err_cnt;

    modport slave (
        input  req0, req1, we0, we1, a0, a1, wd0, wd1, bus_rd,
        output gnt0, gnt1, ack0, ack1, rd, bus_a, bus_we, bus_wd,
        output err, err_addr, err_cnt
    );

    modport master (
        output req0, req1, we0, we1, a0, a1, wd0, wd1, bus_rd,
        input  gnt0, gnt1, ack0, ack1, rd, bus_a, bus_we, bus_wd,
        input  err, err_addr, err_cnt
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares the system bus between master 0 (CPU) and master 1 (DMA). The granted
// master's address/write-enable/write-data are forwarded to the address decoder;
// beats to unmapped addresses are acknowledged but have their write suppressed
// and are reported through err/err_addr/err_cnt.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bif  : bus_arbiter_if.slave (requests, grants, acks, decoder bus, error status)
// Parameters:
//   MAX_HOLD : beats a master may keep the bus while the other is requesting (1..255)
//
// state  | meaning
// IDLE   | no grant; bus outputs 0
// GRANT0 | master 0 (CPU) owns the bus
// GRANT1 | master 1 (DMA) owns the bus
module bus_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input logic        clk,
    input logic        rst,
    bus_arbiter_if.slave bif
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state;
    logic        last;
    logic [7:0]  hold_cnt;

    logic        beat0;
    logic        beat1;
    logic        beat;
    logic [31:0] sel_a;
    logic [31:0] sel_wd;
    logic        sel_we;
    logic        mapped;

    function automatic logic is_mapped(input logic [31:0] addr);
        return (addr <= 32'h0000_00FC) ||
               (addr >= 32'h0000_0800 && addr <= 32'h0000_080C) ||
               (addr >= 32'h0000_0900 && addr <= 32'h0000_090C) ||
               (addr >= 32'h0000_0A00 && addr <= 32'h0000_0A0C);
    endfunction

    always_comb begin
        beat0  = bif.req0 & bif.gnt0;
        beat1  = bif.req1 & bif.gnt1;
        beat   = beat0 | beat1;
        sel_a  = 32'h0;
        sel_wd = 32'h0;
        sel_we = 1'b0;
        if (beat0) begin
            sel_a  = bif.a0;
            sel_wd = bif.wd0;
            sel_we = bif.we0;
        end else if (beat1) begin
            sel_a  = bif.a1;
            sel_wd = bif.wd1;
            sel_we = bif.we1;
        end
        mapped = is_mapped(sel_a);
    end

    assign bif.ack0   = beat0;
    assign bif.ack1   = beat1;
    assign bif.bus_a  = sel_a;
    assign bif.bus_wd = sel_wd;
    // Unmapped beats are still acked so the master never stalls, but must not write.
    assign bif.bus_we = sel_we & mapped;
    assign bif.rd     = bif.bus_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bif.gnt0     <= 1'b0;
            bif.gnt1     <= 1'b0;
            last         <= 1'b1;
            hold_cnt     <= 8'h0;
            bif.err      <= 1'b0;
            bif.err_addr <= 32'h0;
            bif.err_cnt  <= 8'h0;
        end else begin
            bif.err <= beat & ~mapped;
            if (beat && !mapped) begin
                bif.err_addr <= sel_a;
                if (bif.err_cnt != 8'hFF) bif.err_cnt <= bif.err_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    // On a tie the master that did not own the bus last wins.
                    if (bif.req0 && (!bif.req1 || last)) begin
                        state    <= GRANT0;
                        bif.gnt0 <= 1'b1;
                        last     <= 1'b0;
                        hold_cnt <= 8'h0;
                    end else if (bif.req1) begin
                        state    <= GRANT1;
                        bif.gnt1 <= 1'b1;
                        last     <= 1'b1;
                        hold_cnt <= 8'h0;
                    end
                end
                GRANT0: begin
                    if (!bif.req0 || (bif.req1 && hold_cnt == HOLD_LAST)) begin
                        bif.gnt0 <= 1'b0;
                        if (bif.req1) begin
                            state    <= GRANT1;
                            bif.gnt1 <= 1'b1;
                            last     <= 1'b1;
                            hold_cnt <= 8'h0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        // Staying with req0 high means a beat happened this cycle.
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GRANT1: begin
                    if (!bif.req1 || (bif.req0 && hold_cnt == HOLD_LAST)) begin
                        bif.gnt1 <= 1'b0;
                        if (bif.req0) begin
                            state    <= GRANT0;
                            bif.gnt0 <= 1'b1;
                            last     <= 1'b0;
                            hold_cnt <= 8'h0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bif.gnt0 <= 1'b0;
                    bif.gnt1 <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_arbiter_if bif();

    bus_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        r0;
        logic        w0;
        logic [31:0] a0;
        logic [31:0] wd0;
        logic        r1;
        logic        w1;
        logic [31:0] a1;
        logic [31:0] wd1;
        logic [31:0] brd;
        logic        g0;
        logic        g1;
        logic        k0;
        logic        k1;
        logic [31:0] ba;
        logic        bwe;
        logic [31:0] bwd;
        logic        err;
        logic [31:0] eaddr;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        string n, logic rs,
        logic r0, logic w0, logic [31:0] a0, logic [31:0] wd0,
        logic r1, logic w1, logic [31:0] a1, logic [31:0] wd1,
        logic [31:0] brd,
        logic g0, logic g1, logic k0, logic k1,
        logic [31:0] ba, logic bwe, logic [31:0] bwd,
        logic er, logic [31:0] eaddr, logic [7:0] ecnt);
        vec_t v;
        v.name = n;   v.rst = rs;
        v.r0 = r0;    v.w0 = w0;   v.a0 = a0;   v.wd0 = wd0;
        v.r1 = r1;    v.w1 = w1;   v.a1 = a1;   v.wd1 = wd1;
        v.brd = brd;
        v.g0 = g0;    v.g1 = g1;   v.k0 = k0;   v.k1 = k1;
        v.ba = ba;    v.bwe = bwe; v.bwd = bwd;
        v.err = er;   v.eaddr = eaddr; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(string vn, string f, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", vn, f, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        @(posedge clk);
        #1;
        rst        = v.rst;
        bif.req0   = v.r0;
        bif.we0    = v.w0;
        bif.a0     = v.a0;
        bif.wd0    = v.wd0;
        bif.req1   = v.r1;
        bif.we1    = v.w1;
        bif.a1     = v.a1;
        bif.wd1    = v.wd1;
        bif.bus_rd = v.brd;
        sb.push_back(v);
    endtask

    always @(negedge clk) begin : monitor
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "gnt0",     32'(bif.gnt0),    32'(e.g0));
            chk(e.name, "gnt1",     32'(bif.gnt1),    32'(e.g1));
            chk(e.name, "ack0",     32'(bif.ack0),    32'(e.k0));
            chk(e.name, "ack1",     32'(bif.ack1),    32'(e.k1));
            chk(e.name, "bus_a",    bif.bus_a,        e.ba);
            chk(e.name, "bus_we",   32'(bif.bus_we),  32'(e.bwe));
            chk(e.name, "bus_wd",   bif.bus_wd,       e.bwd);
            chk(e.name, "rd",       bif.rd,           e.brd);
            chk(e.name, "err",      32'(bif.err),     32'(e.err));
            chk(e.name, "err_addr", bif.err_addr,     e.eaddr);
            chk(e.name, "err_cnt",  32'(bif.err_cnt), 32'(e.ecnt));
        end
    end

    initial begin
        logic m0;
        rst = 1'b1;
        bif.req0 = 1'b0; bif.we0 = 1'b0; bif.a0 = '0; bif.wd0 = '0;
        bif.req1 = 1'b0; bif.we1 = 1'b0; bif.a1 = '0; bif.wd1 = '0;
        bif.bus_rd = '0;

        // single write, unmapped/edge-of-range writes, read
        tbl.push_back(mk("rst",    1, 0,0,32'h0,0,            0,0,0,0, 0,      0,0,0,0, 32'h0,0,0,            0,32'h0,0));
        tbl.push_back(mk("wr_req", 0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,     0,0,0,0, 32'h0,0,0,            0,32'h0,0));
        tbl.push_back(mk("wr_bt",  0, 1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,     1,0,1,0, 32'h10,1,32'hDEADBEEF,0,32'h0,0));
        tbl.push_back(mk("wr_rel", 0, 0,0,32'h0,0,            0,0,0,0, 0,      1,0,0,0, 32'h0,0,0,            0,32'h0,0));
        tbl.push_back(mk("wr_idl", 0, 0,0,32'h0,0,            0,0,0,0, 0,      0,0,0,0, 32'h0,0,0,            0,32'h0,0));
        tbl.push_back(mk("u_req",  0, 1,1,32'h400,1,          0,0,0,0, 0,      0,0,0,0, 32'h0,0,0,            0,32'h0,0));
        tbl.push_back(mk("u_400",  0, 1,1,32'h400,1,          0,0,0,0, 0,      1,0,1,0, 32'h400,0,1,          0,32'h0,0));
        tbl.push_back(mk("u_80d",  0, 1,1,32'h80D,2,          0,0,0,0, 0,      1,0,1,0, 32'h80D,0,2,          1,32'h400,1));
        tbl.push_back(mk("m_0fc",  0, 1,1,32'h0FC,3,          0,0,0,0, 0,      1,0,1,0, 32'h0FC,1,3,          1,32'h80D,2));
        tbl.push_back(mk("m_80c",  0, 1,1,32'h80C,4,          0,0,0,0, 0,      1,0,1,0, 32'h80C,1,4,          0,32'h80D,2));
        tbl.push_back(mk("m_90c",  0, 1,1,32'h90C,5,          0,0,0,0, 0,      1,0,1,0, 32'h90C,1,5,          0,32'h80D,2));
        tbl.push_back(mk("m_a0c",  0, 1,1,32'hA0C,6,          0,0,0,0, 0,      1,0,1,0, 32'hA0C,1,6,          0,32'h80D,2));
        tbl.push_back(mk("u_0fd",  0, 1,1,32'h0FD,7,          0,0,0,0, 0,      1,0,1,0, 32'h0FD,0,7,          0,32'h80D,2));
        tbl.push_back(mk("rd_900", 0, 1,0,32'h900,0,          0,0,0,0, 32'h5A, 1,0,1,0, 32'h900,0,0,          1,32'h0FD,3));
        tbl.push_back(mk("rd_rel", 0, 0,0,32'h0,0,            0,0,0,0, 0,      1,0,0,0, 32'h0,0,0,            0,32'h0FD,3));
        tbl.push_back(mk("rd_idl", 0, 0,0,32'h0,0,            0,0,0,0, 0,      0,0,0,0, 32'h0,0,0,            0,32'h0FD,3));

        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // master 1 alone for 10 beats
        apply(mk("m1_req", 0, 0,0,0,0, 1,0,32'h20,0, 0, 0,0,0,0, 0,0,0, 0,32'h0FD,3));
        for (int i = 0; i < 10; i++) begin
            apply(mk($sformatf("m1_b%0d", i), 0, 0,0,0,0, 1,0,32'h20 + 32'(4*i),0, 32'h100 + 32'(i),
                     0,1,0,1, 32'h20 + 32'(4*i),0,0, 0,32'h0FD,3));
        end
        apply(mk("m1_rel", 0, 0,0,0,0, 0,0,0,0, 0, 0,1,0,0, 0,0,0, 0,32'h0FD,3));
        apply(mk("m1_idl", 0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,32'h0FD,3));

        // continuous contention, reset landing in the middle of an M0 burst
        apply(mk("ct_req", 0, 1,1,32'h40,32'hA0, 1,1,32'h80,32'hB1, 0, 0,0,0,0, 0,0,0, 0,32'h0FD,3));
        for (int i = 0; i < 19; i++) begin
            m0 = ((i / 4) % 2) == 0;
            apply(mk($sformatf("ct_%0d", i), (i == 18), 1,1,32'h40,32'hA0, 1,1,32'h80,32'hB1, 32'(i),
                     m0,!m0,m0,!m0, m0 ? 32'h40 : 32'h80, 1, m0 ? 32'hA0 : 32'hB1, 0,32'h0FD,3));
        end
        apply(mk("rs_idl", 0, 1,1,32'h40,32'hA0, 1,1,32'h80,32'hB1, 0, 0,0,0,0, 0,0,0, 0,32'h0,0));
        for (int j = 0; j < 5; j++) begin
            m0 = (j < 4);
            apply(mk($sformatf("rs_%0d", j), 0, 1,1,32'h40,32'hA0, 1,1,32'h80,32'hB1, 0,
                     m0,!m0,m0,!m0, m0 ? 32'h40 : 32'h80, 1, m0 ? 32'hA0 : 32'hB1, 0,32'h0,0));
        end

        // owner drops its request while the other waits: handover without idle
        apply(mk("ho_drop", 0, 1,1,32'h40,32'hA0, 0,0,0,0, 0, 0,1,0,0, 0,0,0, 0,32'h0,0));
        apply(mk("ho_m0",   0, 1,1,32'h40,32'hA0, 0,0,0,0, 0, 1,0,1,0, 32'h40,1,32'hA0, 0,32'h0,0));
        apply(mk("ho_rel",  0, 0,0,0,0,           0,0,0,0, 0, 1,0,0,0, 0,0,0, 0,32'h0,0));
        apply(mk("ho_idl",  0, 0,0,0,0,           0,0,0,0, 0, 0,0,0,0, 0,0,0, 0,32'h0,0));

        @(negedge clk);
        #1;
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d vectors left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
